// File: rtl/card_pkg.sv
// card_pkg: shared types, card constants, FSM state encoding and card helpers
// for the card-hand datapath.
//   card_t        4-bit card code (0 = empty, 1 = A, 2..10 pips, 11..13 J/Q/K)
//   state_t       request FSM states (IDLE, DRAW, UPDATE)
//   card_value()  scoring value of a card code (0..9)
//   add_mod10()   sum of two 0..9 values, reduced mod 10
package card_pkg;

    typedef logic [3:0] card_t;

    localparam card_t CARD_EMPTY = 4'd0;
    localparam card_t CARD_ACE   = 4'd1;
    localparam card_t CARD_KING  = 4'd13;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAW   = 2'd1,
        UPDATE = 2'd2
    } state_t;

    // Ace through nine count face value; ten and court cards count zero.
    function automatic logic [3:0] card_value(input card_t c);
        return (c >= CARD_ACE && c <= 4'd9) ? c : 4'd0;
    endfunction

    // Both operands are 0..9, so a single conditional subtract suffices.
    function automatic logic [3:0] add_mod10(input logic [3:0] a, input logic [3:0] b);
        logic [4:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum >= 5'd10) ? 4'(sum - 5'd10) : sum[3:0];
    endfunction

endpackage

// File: rtl/card_gen.sv
// card_gen: free-running card generator cycling 1..13 (A..K).
// Ports:
//   clk     clock, rising edge
//   resetb  synchronous active-low reset; loads the ace
//   card    current card code, always within 1..13
module card_gen
    import card_pkg::*;
(
    input  logic  clk,
    input  logic  resetb,
    output card_t card
);

    // The >= comparison also recovers from any out-of-range value.
    always_ff @(posedge clk) begin
        if (!resetb || card >= CARD_KING) begin
            card <= CARD_ACE;
        end else begin
            card <= card + 4'd1;
        end
    end

endmodule

// File: rtl/card_hand_dp.sv
// card_hand_dp: parametrised card-hand datapath. Deal requests draw the
// current generator card and place it in the next free slot of the addressed
// hand while keeping a per-hand score (sum of card values mod 10).
// Ports:
//   slow_clock  clock, rising edge
//   resetb      synchronous active-low reset
//   clear       empties all hands, zeroes scores, aborts any in-flight request
//   deal_valid  deal request
//   deal_hand   target hand index
//   deal_ready  request can be accepted
//   done        one-cycle pulse when a request finishes
//   err         with done: request rejected (bad hand index or hand full)
//   card_out    card drawn by the last completed request
//   cards       packed slots, hand h slot s at [4*(h*CARDS_PER_HAND+s) +: 4]
//   scores      packed per-hand scores (0..9)
//   hand_full   bit h set when hand h has every slot filled
//   hex         (CARD_HAND_HEX_EN only) active-low 7-seg glyph per slot
// Optional feature macro: CARD_HAND_HEX_EN
//
// Handshake: a request transfers on a rising edge where deal_valid and
// deal_ready are both high; deal_hand is captured at that edge. deal_ready
// is high only in IDLE with clear low, and does not depend on deal_valid.
module card_hand_dp
    import card_pkg::*;
#(
    parameter int NUM_HANDS      = 2,
    parameter int CARDS_PER_HAND = 3,
    localparam int HAND_W        = (NUM_HANDS > 1) ? $clog2(NUM_HANDS) : 1
) (
    input  logic                                  slow_clock,
    input  logic                                  resetb,
    input  logic                                  clear,
    input  logic                                  deal_valid,
    input  logic [HAND_W-1:0]                     deal_hand,
    output logic                                  deal_ready,
    output logic                                  done,
    output logic                                  err,
    output card_t                                 card_out,
    output logic [4*NUM_HANDS*CARDS_PER_HAND-1:0] cards,
    output logic [4*NUM_HANDS-1:0]                scores,
    output logic [NUM_HANDS-1:0]                  hand_full
`ifdef CARD_HAND_HEX_EN
    ,
    output logic [7*NUM_HANDS*CARDS_PER_HAND-1:0] hex
`endif
);

    localparam int CNT_W = $clog2(CARDS_PER_HAND + 1);

    state_t              state;
    state_t              next_state;
    card_t               gen_card;
    card_t               lat_card;
    logic [HAND_W-1:0]   lat_hand;
    logic                err_flag;
    logic                reject;
    logic                accept;
    logic                wr_en;

    card_gen u_gen (
        .clk    (slow_clock),
        .resetb (resetb),
        .card   (gen_card)
    );

    assign deal_ready = (state == IDLE) && !clear;
    assign accept     = deal_valid && deal_ready;
    assign wr_en      = (state == UPDATE) && !err_flag;

    // Reject when the latched index names no hand or the named hand is full.
    always_comb begin
        logic in_range;
        logic sel_full;
        in_range = 1'b0;
        sel_full = 1'b0;
        for (int h = 0; h < NUM_HANDS; h++) begin
            if (lat_hand == HAND_W'(h)) begin
                in_range = 1'b1;
                sel_full = hand_full[h];
            end
        end
        reject = !in_range || sel_full;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = DRAW;
            DRAW:    next_state = UPDATE;
            UPDATE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge slow_clock) begin
        if (!resetb) begin
            state    <= IDLE;
            done     <= 1'b0;
            err      <= 1'b0;
            card_out <= CARD_EMPTY;
            lat_hand <= '0;
            lat_card <= CARD_EMPTY;
            err_flag <= 1'b0;
        end else if (clear) begin
            // Abort silently; card_out keeps the last reported card.
            state <= IDLE;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= next_state;
            done  <= (state == UPDATE);
            err   <= (state == UPDATE) && err_flag;
            if (accept) begin
                lat_hand <= deal_hand;
                lat_card <= gen_card;
            end
            if (state == DRAW) begin
                err_flag <= reject;
            end
            if (state == UPDATE) begin
                card_out <= lat_card;
            end
        end
    end

    for (genvar h = 0; h < NUM_HANDS; h++) begin : g_hand
        logic [CNT_W-1:0] fill;
        logic [3:0]       score;
        card_t            slot [CARDS_PER_HAND];
        logic             hit;

        assign hit = wr_en && (lat_hand == HAND_W'(h));

        always_ff @(posedge slow_clock) begin
            if (!resetb || clear) begin
                fill  <= '0;
                score <= 4'd0;
                for (int s = 0; s < CARDS_PER_HAND; s++) begin
                    slot[s] <= CARD_EMPTY;
                end
            end else if (hit) begin
                for (int s = 0; s < CARDS_PER_HAND; s++) begin
                    if (fill == CNT_W'(s)) begin
                        slot[s] <= lat_card;
                    end
                end
                fill  <= fill + CNT_W'(1);
                score <= add_mod10(score, card_value(lat_card));
            end
        end

        assign hand_full[h]     = (fill == CNT_W'(CARDS_PER_HAND));
        assign scores[4*h +: 4] = score;

        for (genvar s = 0; s < CARDS_PER_HAND; s++) begin : g_slot
            assign cards[4*(h*CARDS_PER_HAND+s) +: 4] = slot[s];
`ifdef CARD_HAND_HEX_EN
            logic [6:0] glyph;
            card7seg u_seg (
                .card (slot[s]),
                .seg7 (glyph)
            );
            // Empty slots blank the digit regardless of the glyph table.
            assign hex[7*(h*CARDS_PER_HAND+s) +: 7] =
                (slot[s] == CARD_EMPTY) ? 7'b1111111 : glyph;
`endif
        end
    end

endmodule

// File: tb/tb_card_hand_dp.sv
module tb_card_hand_dp;

    localparam int NH     = 3;
    localparam int CPH    = 3;
    localparam int HW     = 2;
    localparam int CARD_B = 4 * NH * CPH;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              resetb;
    logic              clear;
    logic              deal_valid;
    logic [HW-1:0]     deal_hand;
    logic              deal_ready;
    logic              done;
    logic              err;
    logic [3:0]        card_out;
    logic [CARD_B-1:0] cards;
    logic [4*NH-1:0]   scores;
    logic [NH-1:0]     hand_full;

    card_hand_dp #(.NUM_HANDS(NH), .CARDS_PER_HAND(CPH)) dut (
        .slow_clock (clk),
        .resetb     (resetb),
        .clear      (clear),
        .deal_valid (deal_valid),
        .deal_hand  (deal_hand),
        .deal_ready (deal_ready),
        .done       (done),
        .err        (err),
        .card_out   (card_out),
        .cards      (cards),
        .scores     (scores),
        .hand_full  (hand_full)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Hands are queues of drawn cards; the generator is the count of
    // non-reset edges mod 13; a request is a record that completes two
    // edges after its accept edge.
    logic [3:0] hq [NH][$];
    int         gen_cnt = 0;
    bit         model_valid = 0;
    bit         pend = 0;
    int         pend_age;
    int         pend_hand;
    logic [3:0] pend_card;
    bit         m_done = 0;
    bit         m_err = 0;
    logic [3:0] m_card_out = 4'd0;

    function automatic int val_of(input logic [3:0] c);
        return (c >= 1 && c <= 9) ? int'(c) : 0;
    endfunction

    always @(posedge clk) begin
        if (!resetb) begin
            model_valid = 1;
            gen_cnt     = 0;
            pend        = 0;
            m_done      = 0;
            m_err       = 0;
            m_card_out  = 4'd0;
            for (int h = 0; h < NH; h++) hq[h].delete();
        end else if (model_valid) begin
            bit acc;
            acc    = deal_valid && !pend && !clear;
            m_done = 0;
            m_err  = 0;
            if (clear) begin
                pend = 0;
                for (int h = 0; h < NH; h++) hq[h].delete();
            end else begin
                if (pend) begin
                    pend_age++;
                    if (pend_age == 2) begin
                        if (pend_hand >= NH || hq[pend_hand].size() == CPH) m_err = 1;
                        else hq[pend_hand].push_back(pend_card);
                        m_done     = 1;
                        m_card_out = pend_card;
                        pend       = 0;
                    end
                end
                if (acc) begin
                    pend      = 1;
                    pend_age  = 0;
                    pend_hand = int'(deal_hand);
                    pend_card = 4'(gen_cnt + 1);
                end
            end
            gen_cnt = (gen_cnt + 1) % 13;
        end
    end

    // ---------------- scoreboard compare (every cycle) ----------------
    always @(negedge clk) begin
        if (model_valid) begin
            logic [63:0] exp_cards;
            logic [63:0] exp_scores;
            logic [63:0] exp_full;
            exp_cards  = '0;
            exp_scores = '0;
            exp_full   = '0;
            for (int h = 0; h < NH; h++) begin
                int sum;
                sum = 0;
                for (int s = 0; s < hq[h].size(); s++) begin
                    exp_cards[4*(h*CPH+s) +: 4] = hq[h][s];
                    sum += val_of(hq[h][s]);
                end
                exp_scores[4*h +: 4] = 4'(sum % 10);
                exp_full[h]          = (hq[h].size() == CPH);
            end
            check("ready", 64'(deal_ready), 64'(!pend && !clear));
            check("done", 64'(done), 64'(m_done));
            if (m_done) check("err", 64'(err), 64'(m_err));
            check("card_out", 64'(card_out), 64'(m_card_out));
            check("cards", 64'(cards), exp_cards);
            check("scores", 64'(scores), exp_scores);
            check("hand_full", 64'(hand_full), exp_full);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetb     = 1'b0;
        clear      = 1'b0;
        deal_valid = 1'b0;
        deal_hand  = '0;
        tick();
        tick();
        resetb = 1'b1;
    endtask

    // Issue one deal; want != 0 waits until the generator shows that card.
    task automatic deal(input int hand, input int want, output logic [3:0] drawn,
                        output logic got_err, output logic [3:0] got_card);
        int  waited;
        bit  found;
        waited   = 0;
        found    = 0;
        got_err  = 1'b0;
        got_card = 4'd0;
        while ((pend || clear || (want != 0 && gen_cnt + 1 != want)) && waited < 60) begin
            tick();
            waited++;
        end
        check("deal_wait_bound", 64'(waited < 60), 64'd1);
        deal_valid = 1'b1;
        deal_hand  = HW'(hand);
        drawn      = 4'(gen_cnt + 1);
        tick();
        deal_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done) begin
                found    = 1;
                got_err  = err;
                got_card = card_out;
                check("done_latency", 64'(k), 64'd2);
                break;
            end
        end
        check("done_seen", 64'(found), 64'd1);
        tick();
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        logic [3:0]        drawn;
        logic              g_err;
        logic [3:0]        g_card;
        logic [CARD_B-1:0] snap_cards;
        logic [4*NH-1:0]   snap_scores;
        int                dcyc [$];
        logic [3:0]        dcard [$];

        do_reset();

        // First deal right after reset draws the ace.
        deal(0, 0, drawn, g_err, g_card);
        check("t1_card_out", 64'(g_card), 64'd1);
        check("t1_err", 64'(g_err), 64'd0);
        check("t1_slot00", 64'(cards[3:0]), 64'd1);
        check("t1_score0", 64'(scores[3:0]), 64'd1);

        // 7, K, 5 into hand 0: 7+0+5 = 12 -> 2, hand full.
        do_reset();
        deal(0, 7, drawn, g_err, g_card);
        deal(0, 13, drawn, g_err, g_card);
        deal(0, 5, drawn, g_err, g_card);
        check("t2_slot0", 64'(cards[3:0]), 64'd7);
        check("t2_slot1", 64'(cards[7:4]), 64'd13);
        check("t2_slot2", 64'(cards[11:8]), 64'd5);
        check("t2_score0", 64'(scores[3:0]), 64'd2);
        check("t2_full0", 64'(hand_full[0]), 64'd1);
        check("t2_full1", 64'(hand_full[1]), 64'd0);

        // Fourth deal to the full hand is rejected but reports its card.
        snap_cards  = cards;
        snap_scores = scores;
        deal(0, 0, drawn, g_err, g_card);
        check("t3_err", 64'(g_err), 64'd1);
        check("t3_card_out", 64'(g_card), 64'(drawn));
        check("t3_cards", 64'(cards), 64'(snap_cards));
        check("t3_score0", 64'(scores[3:0]), 64'd2);

        // Hand index 3 does not exist with three hands.
        deal(1, 0, drawn, g_err, g_card);
        snap_cards  = cards;
        snap_scores = scores;
        deal(3, 0, drawn, g_err, g_card);
        check("t4_err", 64'(g_err), 64'd1);
        check("t4_cards", 64'(cards), 64'(snap_cards));
        check("t4_scores", 64'(scores), 64'(snap_scores));

        // Clear during DRAW aborts the request with no done pulse.
        deal_valid = 1'b1;
        deal_hand  = 2'd1;
        tick();
        deal_valid = 1'b0;
        clear      = 1'b1;
        tick();
        clear = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t5_no_done", 64'(done), 64'd0);
        end
        check("t5_cards", 64'(cards), 64'd0);
        check("t5_scores", 64'(scores), 64'd0);
        check("t5_ready", 64'(deal_ready), 64'd1);
        check("t5_full", 64'(hand_full), 64'd0);
        tick();

        // Hold deal_valid for 30 cycles: one accept every 3 cycles, and
        // each drawn card is the previous one advanced by 3 with 13 -> 1 wrap.
        deal_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            deal_hand = HW'(i % 3);
            @(negedge clk);
            if (done) begin
                dcyc.push_back(i);
                dcard.push_back(card_out);
            end
            tick();
        end
        deal_valid = 1'b0;
        check("t6_done_count", 64'(dcyc.size()), 64'd9);
        for (int k = 0; k < dcard.size(); k++) begin
            check("t6_card_range", 64'(dcard[k] >= 1 && dcard[k] <= 13), 64'd1);
            if (k > 0) begin
                check("t6_spacing", 64'(dcyc[k] - dcyc[k-1]), 64'd3);
                check("t6_sequence", 64'(dcard[k]), 64'(((int'(dcard[k-1]) - 1 + 3) % 13) + 1));
            end
        end
        repeat (4) tick();

        // Random traffic; the scoreboard checks every cycle.
        for (int i = 0; i < 1500; i++) begin
            resetb     = ($urandom_range(0, 199) != 0);
            clear      = ($urandom_range(0, 39) == 0);
            deal_valid = ($urandom_range(0, 9) < 6);
            deal_hand  = HW'($urandom_range(0, 3));
            tick();
        end
        resetb     = 1'b1;
        clear      = 1'b0;
        deal_valid = 1'b0;
        repeat (5) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

endmodule

// File: doc/card_hand_dp.md
Name: card_hand_dp

Overview:
- Parametrised card-game datapath with NUM_HANDS hands of CARDS_PER_HAND slots each.
- Accepts deal requests over a valid/ready handshake and draws a card from an internal free-running 1..13 generator.
- Writes the card into the next free slot of the addressed hand and maintains a running score (sum of card values mod 10) per hand.
- Sits between the game FSM and the display/score logic; it is the generalised successor of the fixed two-hand, three-card datapath.

Parameters:
- NUM_HANDS, 2, number of hands (1..8).
- CARDS_PER_HAND, 3, card slots per hand (1..8).

Ports:
- slow_clock  in  1  single clock; all state updates on rising edge.
- resetb  in  1  synchronous, active-low reset.
- clear  in  1  empties all hands and zeroes all scores.
- deal_valid  in  1  deal request.
- deal_hand  in  HAND_W  target hand index; HAND_W = max(1, $clog2(NUM_HANDS)).
- deal_ready  out  1  block can accept a request.
- done  out  1  one-cycle pulse; request finished.
- err  out  1  valid only with done; request rejected.
- card_out  out  4  card drawn by the last completed request.
- cards  out  4*NUM_HANDS*CARDS_PER_HAND  packed slots; hand h, slot s at bits [4*(h*CARDS_PER_HAND+s) +: 4].
- scores  out  4*NUM_HANDS  packed per-hand scores, 0..9.
- hand_full  out  NUM_HANDS  bit h set when hand h has all slots filled.

Behaviour:
- Card code: 0 = empty, 1 = A, 2..10 = pip cards, 11 = J, 12 = Q, 13 = K.
  - Card value: codes 1..9 count as themselves; codes 10..13 count as 0.
- Reset (resetb low at a clock edge):
  - All slots, scores, card_out, fill counts = 0.
  - done = err = 0; state = IDLE.
  - Generator = 1.
- Generator: 4-bit counter, advances every cycle (including while busy), 13 -> 1. It never holds 0 or 14..15.
- deal_ready = (state == IDLE) && !clear.
- A request is accepted when deal_valid && deal_ready. In that cycle the block latches deal_hand and the current generator value.
- FSM:
  - IDLE -> DRAW on accept.
  - DRAW -> UPDATE unconditionally. In DRAW the block decides error: err if deal_hand >= NUM_HANDS or the hand is full.
  - UPDATE -> IDLE unconditionally.
    - No error: write slot[fill count] = card, fill count += 1, score = (score + value) mod 10.
    - Error: no slot or score change.
    - In both cases card_out = latched card, done = 1, err = error flag.
  - done is registered and is seen high in the cycle after UPDATE, i.e. 3 cycles after the accept edge. deal_ready returns high in that same cycle, so back-to-back requests have a 3-cycle issue interval.
- clear has priority over everything except reset.
  - Takes effect at the edge where it is sampled: slots, scores and fill counts go to 0; state goes to IDLE.
  - An in-flight request is aborted with no done pulse. card_out is held.
  - The generator is not affected.
- hand_full is combinational from the fill counts.
- scores must always match the mod-10 sum of the occupied slots.

Optional Feature:
- CARD_HAND_HEX_EN defined:
  - Adds output hex [7*NUM_HANDS*CARDS_PER_HAND], packed like cards.
  - Each field is the active-low 7-segment glyph of its slot, produced by instances of the existing card7seg block.
  - Empty slot = all segments off (7'b1111111).
- Undefined: the hex port and all card7seg instances are absent; all other behaviour is identical.

Decomposition:
- Package card_pkg holds:
  - typedef card_t (logic [3:0]) and the constants CARD_EMPTY = 0, CARD_ACE = 1, CARD_KING = 13.
  - The FSM state enum (IDLE, DRAW, UPDATE).
  - Function card_value(card_t) returning 0..9.
- One sub-module, card_gen: the 1..13 wrapping generator with a synchronous active-low reset.
- Per-hand slot storage stays in generate loops in the top module.

Test Plan:
- Reset, then release resetb; assert deal_valid, deal_hand = 0 in the first cycle after release -> card = 1. done is high 3 cycles later with err = 0; slot (0,0) = 1; scores[0] = 1.
- With the default parameters, deal hand 0 with cards 7, 13, 5, forcing the draws by request timing -> scores[0] = 2 (7+0+5 = 12 mod 10); hand_full[0] = 1.
- Fourth deal to the full hand 0 -> done with err = 1; slots and scores[0] unchanged; card_out = the drawn card.
- NUM_HANDS = 3, deal_hand = 3 -> done with err = 1; no state change in any hand.
- Assert clear in the DRAW cycle of a pending deal -> no done pulse, all slots and scores 0, deal_ready = 1 on the next cycle with clear low.
- Hold deal_valid continuously for 30 cycles, sampling the generator -> drawn sequence wraps 13 -> 1. Accepts are spaced 3 cycles apart and no code outside 1..13 ever appears.
